// File: rtl/fe_fetch_unit_pkg.sv
// Shared widths, constants and bundle types for the fetch stage.
package fe_fetch_unit_pkg;

    localparam int DBITS = 32;
    localparam int INSTBITS = 32;
    localparam int BUS_CANARY_WIDTH = 4;
    localparam logic [BUS_CANARY_WIDTH-1:0] BUS_CANARY_VALUE = 4'hC;
    localparam int FROM_DE_TO_FE_WIDTH = 1;
    localparam int FROM_AGEX_TO_FE_WIDTH = 1 + DBITS;
    localparam logic [DBITS-1:0] STARTPC = 32'h0000_0200;
    localparam int FE_LATCH_WIDTH = INSTBITS + 3 * DBITS + BUS_CANARY_WIDTH;

    typedef struct packed {
        logic [INSTBITS-1:0] inst;
        logic [DBITS-1:0]    pc;
    } fifo_entry_t;

    typedef struct packed {
        logic [INSTBITS-1:0]         inst;
        logic [DBITS-1:0]            pc;
        logic [DBITS-1:0]            pcplus;
        logic [DBITS-1:0]            inst_count;
        logic [BUS_CANARY_WIDTH-1:0] canary;
    } fe_latch_t;

endpackage

// File: rtl/fe_fetch_unit_if.sv
// Instruction-memory request/response channel between fetch and imem.
interface fe_fetch_unit_if;
    import fe_fetch_unit_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [DBITS-1:0]    imem_req_addr;
    logic                imem_resp_valid;
    logic [INSTBITS-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/fe_inst_fifo.sv
// Small instruction buffer of {inst, pc}; flush wins over push/pop.
module fe_inst_fifo
    import fe_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  fifo_entry_t din,
    input  logic        pop,
    output fifo_entry_t head,
    output logic [CW-1:0] count,
    output logic        full,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fe_fetch_unit.sv
// Fetch stage: credit-limited imem requests, instruction buffer, FE latch.
module fe_fetch_unit
    import fe_fetch_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter logic [DBITS-1:0] START_PC = STARTPC,
    parameter logic [BUS_CANARY_WIDTH-1:0] CANARY = BUS_CANARY_VALUE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [FROM_DE_TO_FE_WIDTH-1:0] from_DE_to_FE,
    input  logic [FROM_AGEX_TO_FE_WIDTH-1:0] from_AGEX_to_FE,
    fe_fetch_unit_if.master imem,
    output logic [FE_LATCH_WIDTH-1:0] FE_latch_out
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic             br_cond;
    logic [DBITS-1:0] br_target;
    logic             stall;

    logic [DBITS-1:0] fetch_pc;
    logic [DBITS-1:0] deliver_pc;
    logic [DBITS-1:0] inst_count;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop_cnt;
    logic [CW-1:0]    fifo_count;
    logic [CW+1:0]    used;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_fire;
    logic             live;
    logic             pop;
    fifo_entry_t      head;
    fe_latch_t        latch_q;

    assign {br_cond, br_target} = from_AGEX_to_FE;
    assign stall = from_DE_to_FE[0];

    // Buffered, requested and doomed words all hold a buffer slot.
    assign used = (CW+2)'(fifo_count) + (CW+2)'(inflight)
                + (CW+2)'(drop_cnt);

    assign imem.imem_req_valid = reset_n && !br_cond
                              && (used < (CW+2)'(FIFO_DEPTH));
    assign imem.imem_req_addr = fetch_pc;

    assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
    assign live = imem.imem_resp_valid && !br_cond && (drop_cnt == '0);
    assign pop = !br_cond && !stall && !fifo_empty;

    assign FE_latch_out = latch_q;

    fe_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (br_cond),
        .push  (live),
        .din   ('{inst: imem.imem_resp_data, pc: deliver_pc}),
        .pop   (pop),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= START_PC;
            deliver_pc <= START_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            inst_count <= '0;
            latch_q    <= '0;
        end else if (br_cond) begin
            fetch_pc   <= br_target;
            deliver_pc <= br_target;
            inflight   <= '0;
            drop_cnt   <= drop_cnt + inflight
                        - CW'(imem.imem_resp_valid);
            latch_q    <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem.imem_resp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (live) begin
                deliver_pc <= deliver_pc + 32'd4;
            end
            inflight <= inflight + CW'(req_fire) - CW'(live);
            if (!stall) begin
                if (!fifo_empty) begin
                    latch_q <= '{inst:       head.inst,
                                 pc:         head.pc,
                                 pcplus:     head.pc + 32'd4,
                                 inst_count: inst_count + 32'd1,
                                 canary:     CANARY};
                    inst_count <= inst_count + 32'd1;
                end else begin
                    latch_q <= '0;
                end
            end
        end
    end

    a_credit : assert property (@(posedge clk) disable iff (!reset_n)
        used <= (CW+2)'(FIFO_DEPTH));

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
        !(live && fifo_full));

endmodule

// File: tb/tb_fe_fetch_unit.sv
// Randomized bench for fe_fetch_unit with an in-bench queue model.
module tb_fe_fetch_unit;
    import fe_fetch_unit_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic stall = 1'b0;
    logic br = 1'b0;
    logic [31:0] tgt = '0;
    logic [FE_LATCH_WIDTH-1:0] latch_out;

    fe_fetch_unit_if imem();

    fe_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .from_DE_to_FE   (stall),
        .from_AGEX_to_FE ({br, tgt}),
        .imem            (imem),
        .FE_latch_out    (latch_out)
    );

    always #5 clk = ~clk;

    memreq_t     memq[$];
    bit          outq[$];
    logic [31:0] fifoq[$];
    logic [31:0] m_fetch;
    logic [31:0] m_deliver;
    logic [31:0] m_count;
    fe_latch_t   m_latch;
    logic        exp_valid;
    fe_latch_t   cap[$];
    int lat = 1;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a * 32'h9E37_79B1) ^ 32'h0000_0013) | 32'h1;
    endfunction

    task automatic chk(input string nm,
                       input logic [FE_LATCH_WIDTH-1:0] act,
                       input logic [FE_LATCH_WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fifoq.delete();
        outq.delete();
        memq.delete();
        m_fetch = 32'h200;
        m_deliver = 32'h200;
        m_count = '0;
        m_latch = '0;
    endtask

    task automatic model_update();
        logic [31:0] pc;
        bit l;
        logic resp;
        resp = imem.imem_resp_valid;
        if (resp && memq.size() > 0) void'(memq.pop_front());
        if (imem.imem_req_valid && imem.imem_req_ready)
            memq.push_back('{addr: imem.imem_req_addr, due: cyc + lat});
        if (br) begin
            foreach (outq[i]) outq[i] = 1'b0;
            if (resp && outq.size() > 0) void'(outq.pop_front());
            fifoq.delete();
            m_fetch = tgt;
            m_deliver = tgt;
            m_latch = '0;
        end else begin
            if (!stall) begin
                if (fifoq.size() > 0) begin
                    pc = fifoq.pop_front();
                    m_count = m_count + 32'd1;
                    m_latch = '{inst: mem_word(pc), pc: pc,
                                pcplus: pc + 32'd4,
                                inst_count: m_count,
                                canary: BUS_CANARY_VALUE};
                end else begin
                    m_latch = '0;
                end
            end
            if (resp && outq.size() > 0) begin
                l = outq.pop_front();
                if (l) begin
                    fifoq.push_back(m_deliver);
                    m_deliver = m_deliver + 32'd4;
                end
            end
            if (exp_valid && imem.imem_req_ready) begin
                outq.push_back(1'b1);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic step();
        fe_latch_t o;
        @(negedge clk);
        if (!reset_n) model_reset();
        exp_valid = reset_n && !br
                 && (fifoq.size() + outq.size() < DEPTH);
        chk("req_valid", imem.imem_req_valid, exp_valid);
        if (exp_valid) chk("req_addr", imem.imem_req_addr, m_fetch);
        chk("latch", latch_out, m_latch);
        o = latch_out;
        if (o.inst != '0) cap.push_back(o);
        if (reset_n) model_update();
        @(posedge clk);
        #1;
        cyc++;
        imem.imem_resp_valid = reset_n && memq.size() > 0
                            && memq[0].due <= cyc;
        imem.imem_resp_data = imem.imem_resp_valid
                            ? mem_word(memq[0].addr) : '0;
    endtask

    fe_latch_t l;
    int k;

    initial begin
        imem.imem_req_ready = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data = '0;
        repeat (2) step();
        reset_n = 1'b1;
        cap.delete();

        // Back-to-back fetch from the start PC.
        repeat (12) step();
        chk("A_seen3", cap.size() >= 3, 1);
        if (cap.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                l = cap[i];
                chk($sformatf("A_pc%0d", i), l.pc, 32'h200 + 4 * i);
                chk($sformatf("A_pcplus%0d", i), l.pcplus,
                    32'h204 + 4 * i);
                chk($sformatf("A_cnt%0d", i), l.inst_count, i + 1);
                chk($sformatf("A_inst%0d", i), l.inst,
                    mem_word(32'h200 + 4 * i));
                chk($sformatf("A_canary%0d", i), l.canary, 4'hC);
            end
        end

        // Stall while the latch holds 0x208.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        k = 0;
        l = latch_out;
        while (l.pc != 32'h208 && k < 30) begin
            step();
            l = latch_out;
            k++;
        end
        chk("B_reach208", l.pc, 32'h208);
        stall = 1'b1;
        repeat (3) step();
        chk("B_valid_low", imem.imem_req_valid, 1'b0);
        chk("B_hold_pc", l.pc, 32'h208);
        stall = 1'b0;
        cap.delete();
        repeat (3) step();
        chk("B_seen3", cap.size() >= 3, 1);
        if (cap.size() >= 3) begin
            l = cap[1];
            chk("B_pc20c", l.pc, 32'h20C);
            l = cap[2];
            chk("B_pc210", l.pc, 32'h210);
        end

        // Redirect with two slow requests outstanding.
        lat = 3;
        repeat (3) step();
        br = 1'b1;
        tgt = 32'h400;
        step();
        br = 1'b0;
        cap.delete();
        k = 0;
        while (cap.size() == 0 && k < 40) begin
            step();
            k++;
        end
        chk("C_seen", cap.size() > 0, 1);
        if (cap.size() > 0) begin
            l = cap[0];
            chk("C_pc400", l.pc, 32'h400);
            chk("C_inst400", l.inst, mem_word(32'h400));
        end

        // Redirect coinciding with a stall and a response.
        lat = 2;
        k = 0;
        while (!imem.imem_resp_valid && k < 20) begin
            step();
            k++;
        end
        chk("D_resp_seen", imem.imem_resp_valid, 1'b1);
        br = 1'b1;
        stall = 1'b1;
        tgt = 32'h300;
        step();
        br = 1'b0;
        stall = 1'b0;
        chk("D_bubble", latch_out, '0);
        cap.delete();
        k = 0;
        while (cap.size() == 0 && k < 40) begin
            step();
            k++;
        end
        chk("D_seen", cap.size() > 0, 1);
        if (cap.size() > 0) begin
            l = cap[0];
            chk("D_pc300", l.pc, 32'h300);
        end

        // Memory refuses requests for five cycles.
        lat = 1;
        imem.imem_req_ready = 1'b0;
        repeat (5) step();
        chk("E_bubble", latch_out, '0);
        imem.imem_req_ready = 1'b1;
        repeat (8) step();

        // Reset with a request in flight.
        lat = 3;
        k = 0;
        while (memq.size() == 0 && k < 10) begin
            step();
            k++;
        end
        chk("F_inflight", memq.size() > 0, 1);
        reset_n = 1'b0;
        #1;
        chk("F_rst_latch", latch_out, '0);
        repeat (2) step();
        reset_n = 1'b1;
        lat = 1;
        cap.delete();
        k = 0;
        while (cap.size() == 0 && k < 20) begin
            step();
            k++;
        end
        chk("F_seen", cap.size() > 0, 1);
        if (cap.size() > 0) begin
            l = cap[0];
            chk("F_pc200", l.pc, 32'h200);
            chk("F_cnt1", l.inst_count, 32'd1);
        end

        // Random traffic, redirects and wrap-around targets.
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 4);
            imem.imem_req_ready = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 5) == 0)
                tgt = 32'hFFFF_FFF4;
            else
                tgt = $urandom & 32'h0000_FFFC;
            step();
        end
        br = 1'b0;
        stall = 1'b0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
